intra_edge_serializer: RTL and testbench
========================================

INTRA_EDGE_SERIALIZER -- requirements
Module: intra_edge_serializer

Interface
REQ-001 The block SHALL have parameter PX_W, default 30, meaning pixel width in bits.
REQ-002 The block SHALL have parameter MAX_PX, default 8, meaning maximum input edge length; the array depth is 2*MAX_PX+1.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upsampled_array and numPx are valid.
REQ-006 in_ready  output  1  block can accept a new edge.
REQ-007 upsampled_array  input  PX_W x (2*MAX_PX+1)  upsampled edge; entry 0 is the reference-side sample.
REQ-008 numPx  input  10  original (pre-upsample) edge length.
REQ-009 out_data  output  PX_W  current serial sample.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 out_index  output  5  index of out_data within the array.
REQ-013 out_last  output  1  current sample is the final sample of the edge.
REQ-014 busy  output  1  high while in SEND.

Function
REQ-015 The block SHALL implement the states IDLE and SEND.
REQ-016 In IDLE, in_ready SHALL be 1, out_valid 0 and busy 0.
REQ-017 On a cycle with in_valid=1 and in_ready=1, the block SHALL register the array, set count=2*n+1 (n=effective numPx, 11-bit arithmetic), set idx=0 and enter SEND.
REQ-018 The first out_valid SHALL occur the cycle after acceptance, giving 1-cycle latency.
REQ-019 In SEND, in_ready SHALL be 0, out_valid 1 and busy 1, with out_data=buf[idx], out_index=idx and out_last=(idx==count-1).
REQ-020 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-021 On out_valid and out_ready with out_last=0, idx SHALL increment by 1.
REQ-022 On out_valid and out_ready with out_last=1, the block SHALL enter IDLE; in_ready is 1 on the following cycle, so there is a one-cycle minimum gap between edges.
REQ-023 Input changes during SEND SHALL have no effect, because the buffer is captured only at acceptance.
REQ-024 An edge SHALL produce exactly count beats, and idx SHALL never exceed 2*MAX_PX.

Reset
REQ-025 While rst=1, the state SHALL be IDLE and the outputs SHALL be in_ready=0, out_valid=0, out_last=0, out_index=0, out_data=0 and busy=0.
REQ-026 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-027 When rst is asserted mid-SEND, the block SHALL abort the edge, discard the buffer and drive out_valid=0 from the next edge on.
REQ-028 The buffer contents need not be cleared, but out_data SHALL read 0 while out_valid=0.

Configuration
REQ-029 The block SHALL support the macro INTRA_EDGE_SER_ERR_EN.
REQ-030 With INTRA_EDGE_SER_ERR_EN defined, an output port err (1 bit) SHALL exist.
REQ-031 With INTRA_EDGE_SER_ERR_EN defined, an accepted edge with numPx==0 or numPx>MAX_PX SHALL be consumed with no output beats; err pulses high for 1 cycle after acceptance and the block stays in IDLE.
REQ-032 With INTRA_EDGE_SER_ERR_EN undefined, numPx==0 SHALL be treated as 1 and numPx>MAX_PX as MAX_PX, and no err port SHALL exist.

Verification
REQ-033 Bench scenario, basic streaming: rst for 3 cycles, then numPx=8 with array[i]=10*i+150 and out_ready tied 1 -> 17 beats, out_data 150,160,...,310, out_index 0..16 and out_last only on index 16; in_ready returns 1 after 1 gap cycle.
REQ-034 Bench scenario, backpressure: numPx=2 with array 150,15,50,23,4 and out_ready toggling 1,0,0,1 -> beats 150,15,50,23,4 in order, each value held stable through ready-low cycles, 5 handshakes total.
REQ-035 Bench scenario, input change mid-send: change upsampled_array and numPx after acceptance of numPx=3 -> output is still the captured 7 values, and in_valid stays ignored until IDLE.
REQ-036 Bench scenario, reset mid-send: assert rst at beat 4 of 17 -> out_valid=0 next cycle; after release, a new numPx=1 edge yields exactly 3 beats.
REQ-037 Bench scenario, boundary numPx: numPx=0 and numPx=12 -> with INTRA_EDGE_SER_ERR_EN defined, no beats and an err 1-cycle pulse each; without the macro, 3 beats and 17 beats respectively.

Source files
------------

// File: rtl/intra_edge_serializer.sv
// intra_edge_serializer: captures an upsampled edge and streams it out one sample per handshake.
// Optional INTRA_EDGE_SER_ERR_EN adds an err pulse and drops edges with out-of-range numPx.
module intra_edge_serializer #(
  parameter int PX_W = 30,
  parameter int MAX_PX = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [(2*MAX_PX+1)*PX_W-1:0]     upsampled_array,
  input  logic [9:0]                       numPx,
  output logic [PX_W-1:0]                  out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [4:0]                       out_index,
  output logic                             out_last,
  output logic                             busy
`ifdef INTRA_EDGE_SER_ERR_EN
  ,
  output logic                             err
`endif
);
  localparam int DEPTH = 2*MAX_PX+1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, next_state;
  logic [PX_W-1:0] mem [DEPTH];
  logic [10:0] count, n;
  logic [4:0] idx;
  logic accept, reject, last;
  assign accept = in_valid && in_ready;
  assign n = numPx == 10'd0 ? 11'd1 : numPx > 10'(MAX_PX) ? 11'(MAX_PX) : {1'b0, numPx};
  assign last = {6'd0, idx} == count - 11'd1;
`ifdef INTRA_EDGE_SER_ERR_EN
  assign reject = numPx == 10'd0 || numPx > 10'(MAX_PX);
  always_ff @(posedge clk)
    err <= rst ? 1'b0 : accept && reject;
`else
  assign reject = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (accept && !reject ? SEND : IDLE)
                               : (out_ready && last ? IDLE : SEND);
  always_ff @(posedge clk)
    if (rst) begin
      idx <= 5'd0;
      count <= 11'd0;
    end else if (accept) begin
      idx <= 5'd0;
      count <= (n << 1) + 11'd1;
    end else if (out_valid && out_ready && !last)
      idx <= idx + 5'd1;
  // Buffer is left uncleared on reset; outputs are masked whenever nothing is valid.
  always_ff @(posedge clk)
    if (accept)
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= upsampled_array[i*PX_W +: PX_W];
  always_comb begin
    in_ready = !rst && state == IDLE;
    out_valid = !rst && state == SEND;
    busy = out_valid;
    out_last = out_valid && last;
    out_index = out_valid ? idx : 5'd0;
    out_data = out_valid ? mem[idx] : '0;
  end
endmodule

// File: tb/tb_intra_edge_serializer.sv
// tb_intra_edge_serializer: model-checked directed scenarios for intra_edge_serializer.
module tb_intra_edge_serializer;
  localparam int PX_W = 30;
  localparam int MAX_PX = 8;
  localparam int DEPTH = 2*MAX_PX+1;
  typedef struct {int data; int index; bit last;} beat_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, busy;
  logic [DEPTH*PX_W-1:0] upsampled_array;
  logic [9:0] numPx = 0;
  logic [PX_W-1:0] out_data;
  logic [4:0] out_index;
  logic [PX_W-1:0] tb_arr [DEPTH];
  beat_t q[$];
  int hs_log[$];
  int checks = 0, errors = 0, err_pulses = 0;
  bit exp_err = 0;
`ifdef INTRA_EDGE_SER_ERR_EN
  logic err;
`endif
  intra_edge_serializer #(.PX_W(PX_W), .MAX_PX(MAX_PX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .upsampled_array(upsampled_array), .numPx(numPx), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .busy(busy)
`ifdef INTRA_EDGE_SER_ERR_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < DEPTH; i++)
      upsampled_array[i*PX_W +: PX_W] = tb_arr[i];
  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Model: an accepted edge becomes a list of 2n+1 beats taken from the array at acceptance.
  task automatic model_accept();
    int n;
    bit bad;
    bad = numPx == 0 || numPx > MAX_PX;
    n = numPx == 0 ? 1 : numPx > MAX_PX ? MAX_PX : int'(numPx);
`ifdef INTRA_EDGE_SER_ERR_EN
    if (bad) begin
      exp_err = 1;
      return;
    end
`else
    if (bad) n = n;
`endif
    for (int i = 0; i <= 2*n; i++)
      q.push_back('{data: int'(tb_arr[i]), index: i, last: i == 2*n});
  endtask
  always @(negedge clk) begin
    bit exp_vld, exp_rdy;
    exp_vld = !rst && q.size() != 0;
    exp_rdy = !rst && q.size() == 0;
    check("in_ready", int'(in_ready), int'(exp_rdy));
    check("out_valid", int'(out_valid), int'(exp_vld));
    check("busy", int'(busy), int'(exp_vld));
    check("out_data", int'(out_data), exp_vld ? q[0].data : 0);
    check("out_index", int'(out_index), exp_vld ? q[0].index : 0);
    check("out_last", int'(out_last), exp_vld ? int'(q[0].last) : 0);
`ifdef INTRA_EDGE_SER_ERR_EN
    check("err", int'(err), int'(exp_err));
    if (err) err_pulses++;
`endif
    exp_err = 0;
    if (rst) q.delete();
    else begin
      if (exp_vld && out_ready) begin
        hs_log.push_back(int'(out_data));
        void'(q.pop_front());
      end
      if (exp_rdy && in_valid) model_accept();
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_edge(int n);
    for (int t = 0; t < 100 && !in_ready; t++) tick();
    numPx = 10'(n);
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 200 && !in_ready; t++) tick();
    check("idle_reached", int'(in_ready), 1);
  endtask
  task automatic ramp_array();
    for (int i = 0; i < DEPTH; i++) tb_arr[i] = PX_W'(10*i + 150);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] pat;
    int bp [5];
    pat = 4'b1001;
    bp = '{150, 15, 50, 23, 4};
    ramp_array();
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    rst = 0;
    tick();
    check("post_rst_in_ready", int'(in_ready), 1);
    // Basic streaming
    send_edge(8);
    wait_idle();
    check("s1_beats", hs_log.size(), 17);
    check("s1_first", hs_log[0], 150);
    check("s1_last", hs_log[16], 310);
    // Backpressure
    hs_log.delete();
    for (int i = 0; i < 5; i++) tb_arr[i] = PX_W'(bp[i]);
    send_edge(2);
    for (int k = 0; k < 60 && !in_ready; k++) begin
      out_ready = pat[k % 4];
      tick();
    end
    out_ready = 1;
    check("s2_beats", hs_log.size(), 5);
    for (int i = 0; i < 5; i++) check("s2_data", hs_log[i], bp[i]);
    // Input change mid-send
    hs_log.delete();
    for (int i = 0; i < DEPTH; i++) tb_arr[i] = PX_W'(7*i + 1);
    send_edge(3);
    for (int i = 0; i < DEPTH; i++) tb_arr[i] = PX_W'(999);
    numPx = 10'd5;
    in_valid = 1;
    for (int t = 0; t < 100 && !in_ready; t++) tick();
    tick();
    in_valid = 0;
    wait_idle();
    check("s3_beats", hs_log.size(), 18);
    check("s3_captured_end", hs_log[6], 43);
    check("s3_second_edge", hs_log[7], 999);
    // Reset mid-send
    hs_log.delete();
    ramp_array();
    send_edge(8);
    for (int t = 0; t < 100 && hs_log.size() < 4; t++) tick();
    rst = 1;
    tick();
    check("s4_valid_in_rst", int'(out_valid), 0);
    tick();
    rst = 0;
    tick();
    check("s4_beats_before_rst", hs_log.size(), 4);
    hs_log.delete();
    send_edge(1);
    wait_idle();
    check("s4_beats", hs_log.size(), 3);
    check("s4_last_data", hs_log[2], 170);
    // Boundary numPx
    hs_log.delete();
    send_edge(0);
    tick();
    wait_idle();
`ifdef INTRA_EDGE_SER_ERR_EN
    check("s5_zero_beats", hs_log.size(), 0);
    check("s5_zero_err", err_pulses, 1);
`else
    check("s5_zero_beats", hs_log.size(), 3);
`endif
    hs_log.delete();
    send_edge(12);
    tick();
    wait_idle();
`ifdef INTRA_EDGE_SER_ERR_EN
    check("s5_big_beats", hs_log.size(), 0);
    check("s5_big_err", err_pulses, 2);
`else
    check("s5_big_beats", hs_log.size(), 17);
    check("s5_big_last", hs_log[16], 310);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
